// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU operand-fetch / write-back slice.
//   REG_W  datapath width (the external ALU is 32-bit)
//   OP_W   ALUOp width
//   RA_W   register address width
//   ALU_*  ALUOp encodings understood by the external ALU; any other code
//          makes the ALU return 0.
package alu_pkg;

  localparam int REG_W = 32;
  localparam int OP_W  = 3;
  localparam int RA_W  = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [OP_W-1:0] ALU_SRA = 3'b101;

endpackage

// File: rtl/grf.sv
// grf: general register file, NREG x REG_W.
//   clk, rst_n         clock, asynchronous active-low reset (clears every entry)
//   rs_addr/rs_data    asynchronous read port for operand A
//   rt_addr/rt_data    asynchronous read port for operand B
//   dbg_addr/dbg_data  asynchronous debug read port
//   we/wr_addr/wr_data synchronous write port
// Entry 0 is never written, so it always reads zero.
module grf
  import alu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  rs_addr,
  input  logic [RA_W-1:0]  rt_addr,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [REG_W-1:0] rs_data,
  output logic [REG_W-1:0] rt_data,
  output logic [REG_W-1:0] dbg_data,
  input  logic             we,
  input  logic [RA_W-1:0]  wr_addr,
  input  logic [REG_W-1:0] wr_data
);

  logic [REG_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data  = regs[rs_addr];
  assign rt_data  = regs[rt_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_rf.sv
// alu_issue_rf: operand fetch + write-back stage around an external
// combinational ALU. Two stages: ISSUE (alu_a/alu_b/alu_op, ex_rd, ex_valid)
// and WB (register-file write plus wb_* registers).
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake; in_ready never looks at in_valid
//   in_op/in_rs/in_rt/in_rd/in_use_imm/in_imm   command fields
//   alu_a/alu_b/alu_op    registered ALU inputs
//   alu_c                 ALU result (combinational from alu_a/alu_b/alu_op)
//   wb_valid/wb_rd/wb_data  write-back that happened on the last edge
//   dbg_addr/dbg_data     asynchronous debug read of the register file
// Build option: define ALU_ISSUE_BYPASS_EN to forward alu_c into a dependent
// command instead of stalling it for one cycle.
module alu_issue_rf
  import alu_pkg::*;
#(
  parameter int REG_W = 32,  // only 32 matches the external ALU
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [RA_W-1:0]  in_rs,
  input  logic [RA_W-1:0]  in_rt,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_use_imm,
  input  logic [REG_W-1:0] in_imm,
  output logic [REG_W-1:0] alu_a,
  output logic [REG_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [REG_W-1:0] alu_c,
  output logic             wb_valid,
  output logic [RA_W-1:0]  wb_rd,
  output logic [REG_W-1:0] wb_data,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [REG_W-1:0] dbg_data
);

  logic             ex_valid;
  logic [RA_W-1:0]  ex_rd;
  logic [REG_W-1:0] rs_data;
  logic [REG_W-1:0] rt_data;
  logic [REG_W-1:0] opa;
  logic [REG_W-1:0] opb;
  logic             hazard_rs;
  logic             hazard_rt;
  logic             accept;

  grf #(.NREG(NREG)) u_grf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (in_rs),
    .rt_addr  (in_rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data),
    .we       (ex_valid),
    .wr_addr  (ex_rd),
    .wr_data  (alu_c)
  );

  // The command in ISSUE writes its result only at the next edge, so an
  // operand naming its destination would read a stale value from the array.
  assign hazard_rs = ex_valid && (ex_rd != '0) && (in_rs == ex_rd);
  assign hazard_rt = ex_valid && (ex_rd != '0) && !in_use_imm && (in_rt == ex_rd);

`ifdef ALU_ISSUE_BYPASS_EN
  assign in_ready = 1'b1;
  assign opa      = hazard_rs ? alu_c : rs_data;
  assign opb      = in_use_imm ? in_imm : (hazard_rt ? alu_c : rt_data);
`else
  // One bubble is enough: after it ex_valid is 0 and the array holds the result.
  assign in_ready = !(hazard_rs || hazard_rt);
  assign opa      = rs_data;
  assign opb      = in_use_imm ? in_imm : rt_data;
`endif

  assign accept = in_valid && in_ready;

  // ISSUE stage; ALU inputs hold their last values while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_rd  <= in_rd;
        alu_a  <= opa;
        alu_b  <= opb;
        alu_op <= in_op;
      end
    end
  end

  // WB stage; reports writes to r0 too, even though the array ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd   <= ex_rd;
        wb_data <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_rf.sv
module tb_alu_issue_rf;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic        in_use_imm = 1'b0;
  logic [31:0] in_imm = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_rf dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: both the external ALU beside the DUT and the reference.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SRL: return (b >= 32) ? 32'h0 : (a >> b[4:0]);
      ALU_SRA: return (b >= 32) ? {32{a[31]}} : 32'(sa >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  assign alu_c = alu_ref(alu_a, alu_b, alu_op);

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] ref_rf[32];
  int          cyc = 0;
  int          last_cyc = -10;
  logic [4:0]  last_rd = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-back monitor: each accepted command must report exactly one edge later.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check32("wb_valid", 32'(wb_valid), 32'd1);
      check32("wb_rd", 32'(wb_rd), 32'(exp_q[0].rd));
      check32("wb_data", wb_data, exp_q[0].data);
      $display("wb  rd=%0d data=%h", wb_rd, wb_data);
      void'(exp_q.pop_front());
    end else begin
      check32("wb_idle", 32'(wb_valid), 32'd0);
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic use_imm, input logic [31:0] imm);
    logic [31:0] a, b, res;
    bit exp_rdy;
    bit ok;
    int stalls;
    ok = 0;
    stalls = 0;
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_use_imm = use_imm; in_imm = imm;
`ifdef ALU_ISSUE_BYPASS_EN
    exp_rdy = 1;
`else
    exp_rdy = !(last_cyc == cyc && last_rd != 0 && (rs == last_rd || (!use_imm && rt == last_rd)));
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    check32("accept", 32'(ok), 32'd1);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    check32("stall_cycles", 32'(stalls), exp_rdy ? 32'd0 : 32'd1);
    a = ref_rf[rs];
    b = use_imm ? imm : ref_rf[rt];
    res = alu_ref(a, b, op);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check32("alu_op", 32'(alu_op), 32'(op));
    $display("cmd op=%0d rs=%0d rt=%0d rd=%0d imm=%0d/%h stalls=%0d exp=%h",
             op, rs, rt, rd, use_imm, imm, stalls, res);
    last_cyc = cyc;
    last_rd = rd;
    exp_q.push_back('{cyc + 1, rd, res});
    if (rd != 0) ref_rf[rd] = res;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check32("dbg_reg", dbg_data, exp);
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check32("dbg_sweep", dbg_data, ref_rf[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;

    // Reset state
    idle(2);
    check32("rst_wb_valid", 32'(wb_valid), 32'd0);
    dbg_sweep();
    rst_n = 1'b1;
    idle(1);

    // Independent commands
    send(ALU_ADD, 0, 0, 1, 1, 32'd5);
    send(ALU_ADD, 0, 0, 2, 1, 32'd7);
    idle(1);
    send(ALU_SUB, 1, 2, 3, 0, 32'd0);
    idle(2);
    dbg_check(3, 32'hFFFF_FFFE);

    // Back-to-back dependency through rs
    send(ALU_ADD, 0, 0, 4, 1, 32'h8000_0000);
    send(ALU_SRA, 4, 0, 5, 1, 32'd4);
    idle(2);
    dbg_check(5, 32'hF800_0000);

    // Dependency through rt
    send(ALU_OR, 1, 0, 6, 1, 32'h100);
    send(ALU_ADD, 1, 6, 7, 0, 32'd0);
    idle(2);
    dbg_check(7, 32'h0000_010A);

    // Write to r0, then an immediate read of r0 without a stall
    send(ALU_ADD, 0, 0, 0, 1, 32'd9);
    send(ALU_ADD, 0, 0, 6, 1, 32'd3);
    idle(2);
    dbg_check(0, 32'h0);
    dbg_check(6, 32'd3);

    // Shift by 32 and an undefined opcode
    send(ALU_ADD, 0, 0, 7, 1, 32'hFFFF_FFFF);
    send(ALU_SRL, 7, 0, 1, 1, 32'd32);
    send(3'b111, 7, 7, 2, 0, 32'd0);
    idle(2);
    dbg_check(1, 32'h0);
    dbg_check(2, 32'h0);

    // Randomized commands against the sequential reference model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      send(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(2);
    dbg_sweep();

    // Reset while a command sits in ISSUE: it must be dropped
    send(ALU_ADD, 0, 0, 9, 1, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    last_cyc = -10;
    #1;
    check32("rst_alu_a", alu_a, 32'h0);
    check32("rst_alu_b", alu_b, 32'h0);
    check32("rst_alu_op", 32'(alu_op), 32'h0);
    check32("rst_wb_rd", 32'(wb_rd), 32'h0);
    check32("rst_wb_data", wb_data, 32'h0);
    idle(2);
    check32("rst_wb_valid2", 32'(wb_valid), 32'd0);
    dbg_sweep();
    rst_n = 1'b1;
    idle(1);
    send(ALU_ADD, 0, 0, 10, 1, 32'h1234);
    send(ALU_SUB, 10, 0, 11, 1, 32'h34);
    idle(2);
    dbg_check(10, 32'h1234);
    dbg_check(11, 32'h1200);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_rf.md
# alu_issue_rf

Operand-fetch and write-back stage wrapped around the combinational ALU. It accepts one register-to-register or register-immediate command per cycle over a valid/ready handshake and reads operands from a 32×32-bit general register file. It drives the ALU's A, B and ALUOp inputs from an issue register, then captures the ALU result C and writes it back to the destination register one cycle later.

## Interface
Parameters:
- `REG_W`, 32, datapath width; the ALU is 32-bit, so only 32 is supported.
- `NREG`, 32, register count; register 0 is hardwired to zero.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  command present
- `in_ready`  out  1  command accepted this cycle when high together with `in_valid`
- `in_op`  in  3  ALU operation code
- `in_rs`  in  5  source register for A
- `in_rt`  in  5  source register for B (ignored when `in_use_imm`)
- `in_rd`  in  5  destination register
- `in_use_imm`  in  1  B taken from `in_imm` instead of `in_rt`
- `in_imm`  in  32  immediate, already extended
- `alu_a`  out  32  to ALU A
- `alu_b`  out  32  to ALU B
- `alu_op`  out  3  to ALU ALUOp
- `alu_c`  in  32  from ALU C (combinational from `alu_a/alu_b/alu_op`)
- `wb_valid`  out  1  write-back occurred on the last edge
- `wb_rd`  out  5  register written
- `wb_data`  out  32  value written
- `dbg_addr`  in  5  debug read address
- `dbg_data`  out  32  asynchronous read of `rf[dbg_addr]`; reads 0 for address 0

## Operation
- Two-stage pipeline: ISSUE (register `ex_valid`, `ex_rd`, `alu_a`, `alu_b`, `alu_op`) → WB (register-file write plus `wb_*` registers).
- Accept: on an edge with `in_valid && in_ready`, set `alu_a = rf[in_rs]` and `alu_b = in_use_imm ? in_imm : rf[in_rt]`, and load `alu_op = in_op`, `ex_rd = in_rd`, `ex_valid = 1`. Otherwise `ex_valid` is set to 0 and `alu_a/alu_b/alu_op` hold their values.
- Write-back: on an edge with `ex_valid`, perform `rf[ex_rd] <= alu_c` if `ex_rd != 0`. On the same edge, set `wb_valid = 1`, `wb_rd = ex_rd` and `wb_data = alu_c`. For `ex_rd = 0`, `wb_valid` still pulses, `wb_data` shows `alu_c`, and the register file is unchanged.
- Operand ops follow the ALU encoding: 000 add, 001 sub, 010 and, 011 or, 100 logical right shift by B, 101 arithmetic right shift by B, other codes give 0. The full 32-bit B is passed unmasked, so a shift amount of 32 or more yields 0 (or sign fill for 101).
- Add and sub wrap modulo 2^32. No overflow flag is produced.
- Reading register 0 always returns 0.
- Reset (asynchronous, any time, including mid-operation): all `rf` entries, `alu_a`, `alu_b`, `alu_op`, `ex_rd`, `ex_valid`, `wb_valid`, `wb_rd` and `wb_data` go to 0. An in-flight command is dropped and not written back.

## Timing
- The command is accepted at edge N. ALU inputs are valid after N. The register is written and `wb_*` updates at edge N+1. A dependent command accepted at N+1 or later sees the new value: at N+1 via bypass or stall (below), after N+1 from the array.
- `in_ready` is combinational from `in_rs/in_rt/in_use_imm` and `ex_*`. It never depends on `in_valid`.
- Throughput is one command per cycle when there is no hazard.
- A hazard exists when `ex_valid && ex_rd != 0 && (in_rs == ex_rd || (!in_use_imm && in_rt == ex_rd))`.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined:
  - on a hazard, the matching operand is taken from `alu_c`;
  - `in_ready` is constant 1 after reset.
- Undefined:
  - on a hazard, `in_ready = 0` for one cycle; the command is accepted the following cycle and reads the written value from the array;
  - `in_ready` is 1 otherwise.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU opcode localparams `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SRL`, `ALU_SRA`;
  - the widths `REG_W`, `OP_W = 3`, `RA_W = 5`.
- Sub-module `grf` is the register file: three asynchronous read ports (rs, rt, dbg), one synchronous write port, asynchronous active-low reset, and register 0 forced to zero. The hazard, bypass and issue/WB registers live in the top module.
- The ALU itself is instantiated beside this block, not inside it.

## Test plan
- Reset, then `dbg_addr` sweep 0..31 → all read 0. `wb_valid = 0`.
- Two independent commands: rf[1]=5 (via add rs=0, imm 5, rd=1), then add rs=0, imm 7, rd=2 → one edge later `wb_rd=2`, `wb_data=7`. Then sub rs=1, rt=2, rd=3 → `rf[3]=0xFFFFFFFE`.
- Back-to-back dependency: add rs=0, imm 0x80000000, rd=4, immediately followed by sra rs=4, imm 4, rd=5 → `rf[5]=0xF8000000`. With `ALU_ISSUE_BYPASS_EN`, no bubble. Without it, `in_ready=0` for exactly one cycle.
- Write to rd=0 with add imm 9 → `wb_valid=1`, `wb_data=9`, `dbg_data` at address 0 stays 0. A following read of rs=0 with no stall yields 0.
- Shift edge: srl with A=0xFFFFFFFF, imm 32 → 0. Undefined op 111 → 0.
- Assert `rst_n` low while a command is in ISSUE → no write-back occurs and all outputs read 0. After release, the first command behaves normally.
